fsm_arbiter_nreq: RTL and testbench

//   Parametrised N-requester arbiter FSM, next generation of the two-port grant FSM.

---
 rtl/fsm_arb_pkg.sv | 16 +
 rtl/fsm_arbiter_nreq_arb_pick.sv | 47 ++++
 rtl/fsm_arbiter_nreq.sv | 138 +++++++++++++
 tb/tb_fsm_arbiter_nreq.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/fsm_arb_pkg.sv
// Purpose: shared state encodings and priority-mode constants for the N-requester arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fsm_arb_pkg;

  // One-hot state encoding, matching the existing FSMs in this codebase
  typedef enum logic [1:0] {
    ST_IDLE = 2'b01,
    ST_GNT  = 2'b10
  } arb_state_t;

  // Values of the rr_mode input
  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

endpackage

// File: rtl/fsm_arbiter_nreq_arb_pick.sv
// Purpose: combinational pick of one request; fixed priority from index 0, or round-robin from base.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the pick is all-zero when no unmasked request is present.
module arb_pick
  import fsm_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] mask,
  input  logic [IDW-1:0]  base,
  input  logic            mode,
  output logic [NREQ-1:0] pick,
  output logic [IDW-1:0]  pick_id
);

  localparam logic [IDW:0] NREQ_W = (IDW+1)'(NREQ);

  logic [NREQ-1:0] cand;
  logic [IDW:0]    start;

  assign cand  = req & mask;
  assign start = (mode == MODE_RR) ? {1'b0, base} : '0;

  // Scan from the start index, wrapping at NREQ, and keep the first candidate found
  always_comb begin
    logic [IDW:0] sum;
    logic         found;
    pick    = '0;
    pick_id = '0;
    found   = 1'b0;
    sum     = '0;
    for (int i = 0; i < NREQ; i++) begin
      sum = start + (IDW+1)'(i);
      if (sum >= NREQ_W) begin
        sum = sum - NREQ_W;
      end
      if (!found && cand[sum[IDW-1:0]]) begin
        found               = 1'b1;
        pick[sum[IDW-1:0]]  = 1'b1;
        pick_id             = sum[IDW-1:0];
      end
    end
  end

endmodule

// File: rtl/fsm_arbiter_nreq.sv
// Purpose: N-requester grant FSM with run-time fixed/round-robin priority and optional max-hold timeout.
// Latency: 1 cycle from req to registered gnt; owner drop hands over on the next edge with no idle bubble.
// Backpressure: level requests; a requester waits (req held) until granted, timeout forces handover.
module fsm_arbiter_nreq
  import fsm_arb_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int IDW      = 2,
  parameter int MAX_HOLD = 0,
  parameter int HOLD_W   = 8
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [NREQ-1:0] req,
  input  logic            rr_mode,
  output logic [NREQ-1:0] gnt,
  output logic            gnt_valid,
  output logic [IDW-1:0]  gnt_id,
  output logic            hold_tmo
);

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);
  localparam logic [IDW-1:0]    LAST_ID   = IDW'(NREQ - 1);

  arb_state_t      state, state_nxt;
  logic [NREQ-1:0] gnt_nxt;
  logic            gnt_valid_nxt;
  logic [IDW-1:0]  gnt_id_nxt;
  logic            hold_tmo_nxt;
  logic [IDW-1:0]  rr_ptr, rr_ptr_nxt;
  logic [HOLD_W-1:0] hold_cnt, hold_cnt_nxt;

  logic            owner_req;
  logic            others_pend;
  logic            handover;
  logic [NREQ-1:0] pick_mask;
  logic [NREQ-1:0] pick;
  logic [IDW-1:0]  pick_id;

  assign owner_req   = |(req & gnt);
  assign others_pend = |(req & ~gnt);
  // Timeout handover only while the owner still wants the resource; a drop wins otherwise
  assign handover    = (state == ST_GNT) && owner_req && others_pend &&
                       (MAX_HOLD != 0) && (hold_cnt == HOLD_LAST);
  // During a timeout the current owner is excluded so it cannot win again
  assign pick_mask   = handover ? ~gnt : '1;

  arb_pick #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_pick (
    .req     (req),
    .mask    (pick_mask),
    .base    (rr_ptr),
    .mode    (rr_mode),
    .pick    (pick),
    .pick_id (pick_id)
  );

  // State, grant, pointer and hold counter registers; reset clears any grant immediately
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      gnt       <= '0;
      gnt_valid <= 1'b0;
      gnt_id    <= '0;
      hold_tmo  <= 1'b0;
      rr_ptr    <= '0;
      hold_cnt  <= '0;
    end else begin
      state     <= state_nxt;
      gnt       <= gnt_nxt;
      gnt_valid <= gnt_valid_nxt;
      gnt_id    <= gnt_id_nxt;
      hold_tmo  <= hold_tmo_nxt;
      rr_ptr    <= rr_ptr_nxt;
      hold_cnt  <= hold_cnt_nxt;
    end
  end

  // Next-state and next-grant decode; take marks an edge that installs a new owner
  always_comb begin
    logic take;
    take          = 1'b0;
    state_nxt     = state;
    gnt_nxt       = gnt;
    gnt_valid_nxt = gnt_valid;
    gnt_id_nxt    = gnt_id;
    hold_tmo_nxt  = 1'b0;
    rr_ptr_nxt    = rr_ptr;
    hold_cnt_nxt  = hold_cnt;

    case (state)
      ST_IDLE: begin
        if (|req) begin
          take = 1'b1;
        end
      end
      ST_GNT: begin
        if (owner_req) begin
          if (handover) begin
            take         = 1'b1;
            hold_tmo_nxt = 1'b1;
          end else if (others_pend) begin
            hold_cnt_nxt = (hold_cnt == '1) ? hold_cnt : hold_cnt + 1'b1;
          end else begin
            hold_cnt_nxt = '0;
          end
        end else if (|req) begin
          take = 1'b1;
        end else begin
          state_nxt     = ST_IDLE;
          gnt_nxt       = '0;
          gnt_valid_nxt = 1'b0;
          gnt_id_nxt    = '0;
          hold_cnt_nxt  = '0;
        end
      end
      default: begin
        state_nxt     = ST_IDLE;
        gnt_nxt       = '0;
        gnt_valid_nxt = 1'b0;
        gnt_id_nxt    = '0;
        hold_cnt_nxt  = '0;
      end
    endcase

    if (take) begin
      state_nxt     = ST_GNT;
      gnt_nxt       = pick;
      gnt_valid_nxt = 1'b1;
      gnt_id_nxt    = pick_id;
      hold_cnt_nxt  = '0;
      rr_ptr_nxt    = (pick_id == LAST_ID) ? '0 : pick_id + 1'b1;
    end
  end

endmodule

// File: tb/tb_fsm_arbiter_nreq.sv
// Purpose: directed and randomised self-check of fsm_arbiter_nreq (MAX_HOLD=3 and unlimited-hold instances).
// Latency: checks sampled 1 time unit after each rising edge.
// Backpressure: n/a (bench drives level requests directly).
module tb_fsm_arbiter_nreq;

  logic       clock = 1'b0;
  logic       reset;
  logic       rr_mode;
  logic [3:0] req;

  logic [3:0] gnt_a, gnt_b;
  logic       gnt_valid_a, gnt_valid_b;
  logic [1:0] gnt_id_a, gnt_id_b;
  logic       hold_tmo_a, hold_tmo_b;

  int n_checks = 0;
  int n_errors = 0;

  fsm_arbiter_nreq #(.NREQ(4), .IDW(2), .MAX_HOLD(3), .HOLD_W(8)) u_dut (
    .clock     (clock),
    .reset     (reset),
    .req       (req),
    .rr_mode   (rr_mode),
    .gnt       (gnt_a),
    .gnt_valid (gnt_valid_a),
    .gnt_id    (gnt_id_a),
    .hold_tmo  (hold_tmo_a)
  );

  fsm_arbiter_nreq #(.NREQ(4), .IDW(2), .MAX_HOLD(0), .HOLD_W(8)) u_dut_nohold (
    .clock     (clock),
    .reset     (reset),
    .req       (req),
    .rr_mode   (rr_mode),
    .gnt       (gnt_b),
    .gnt_valid (gnt_valid_b),
    .gnt_id    (gnt_id_b),
    .hold_tmo  (hold_tmo_b)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [1:0] enc(input logic [3:0] g);
    enc = '0;
    for (int i = 0; i < 4; i++) begin
      if (g[i]) enc = 2'(i);
    end
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic expect_a(input string tag, input logic [3:0] g, input logic tmo);
    check({tag, ".gnt"},   32'(gnt_a),       32'(g));
    check({tag, ".id"},    32'(gnt_id_a),    32'(enc(g)));
    check({tag, ".vld"},   32'(gnt_valid_a), 32'(|g));
    check({tag, ".tmo"},   32'(hold_tmo_a),  32'(tmo));
  endtask

  task automatic expect_b(input string tag, input logic [3:0] g);
    check({tag, ".gnt_b"}, 32'(gnt_b),       32'(g));
    check({tag, ".id_b"},  32'(gnt_id_b),    32'(enc(g)));
    check({tag, ".vld_b"}, 32'(gnt_valid_b), 32'(|g));
    check({tag, ".tmo_b"}, 32'(hold_tmo_b),  32'(0));
  endtask

  initial begin
    logic [3:0] exp_g;
    logic [3:0] prev_gnt;
    logic [3:0] applied_req;
    logic       applied_mode;
    int         wait_cnt [4];
    int         b;

    reset   = 1'b1;
    req     = 4'b0000;
    rr_mode = 1'b0;
    #12;
    expect_a("reset", 4'b0000, 1'b0);
    expect_b("reset", 4'b0000);
    reset = 1'b0;

    // 1: fixed priority picks lowest index; MAX_HOLD=3 instance times out, unlimited one holds
    req = 4'b1010;
    step(); expect_a("t1.e1", 4'b0010, 1'b0); expect_b("t1.e1", 4'b0010);
    step(); expect_a("t1.e2", 4'b0010, 1'b0); expect_b("t1.e2", 4'b0010);
    step(); expect_a("t1.e3", 4'b0010, 1'b0); expect_b("t1.e3", 4'b0010);
    step(); expect_a("t1.e4", 4'b1000, 1'b1); expect_b("t1.e4", 4'b0010);
    step(); expect_a("t1.e5", 4'b1000, 1'b0); expect_b("t1.e5", 4'b0010);
    req = 4'b0000;
    step(); expect_a("t1.idle", 4'b0000, 1'b0); expect_b("t1.idle", 4'b0000);

    // 2: round-robin, each owner drops after one grant cycle -> 0,1,2,3,0 with no bubble
    rr_mode = 1'b1;
    req     = 4'b1111;
    exp_g   = 4'b0001;
    for (int k = 0; k < 5; k++) begin
      step();
      expect_a($sformatf("t2.g%0d", k), exp_g, 1'b0);
      req   = 4'b1111 & ~exp_g;
      exp_g = {exp_g[2:0], exp_g[3]};
    end
    req = 4'b0000;
    step(); expect_a("t2.idle", 4'b0000, 1'b0);

    // 3: timeout after three contended cycles, then 4: owner drop hands straight to req[3]
    rr_mode = 1'b0;
    req     = 4'b0100;
    step(); expect_a("t3.e1", 4'b0100, 1'b0); expect_b("t3.e1", 4'b0100);
    req = 4'b0101;
    step(); expect_a("t3.e2", 4'b0100, 1'b0);
    step(); expect_a("t3.e3", 4'b0100, 1'b0);
    step(); expect_a("t3.e4", 4'b0001, 1'b1); expect_b("t3.e4", 4'b0100);
    req = 4'b1001;
    step(); expect_a("t4.e5", 4'b0001, 1'b0); expect_b("t4.e5", 4'b0001);
    req = 4'b1000;
    step(); expect_a("t4.e6", 4'b1000, 1'b0); expect_b("t4.e6", 4'b1000);

    // 5: asynchronous reset mid-grant clears outputs before the next edge
    #2 reset = 1'b1;
    #1;
    expect_a("t5.rst", 4'b0000, 1'b0);
    expect_b("t5.rst", 4'b0000);
    req     = 4'b0100;
    rr_mode = 1'b1;
    #2 reset = 1'b0;
    step(); expect_a("t5.post", 4'b0100, 1'b0); expect_b("t5.post", 4'b0100);
    req = 4'b0000;
    step(); expect_a("t5.idle", 4'b0000, 1'b0);
    // rr_ptr now 3 after granting index 2
    req = 4'b1010;
    step(); expect_a("t5.rrptr", 4'b1000, 1'b0); expect_b("t5.rrptr", 4'b1000);
    req = 4'b0000;
    step(); expect_a("t5.end", 4'b0000, 1'b0);

    // 6: random requests and mode, invariant checks every cycle
    for (int k = 0; k < 4; k++) wait_cnt[k] = 0;
    prev_gnt = gnt_a;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      if ($urandom_range(0, 99) < 30) begin
        b   = $urandom_range(0, 3);
        req = req ^ (4'b0001 << b);
      end
      if ($urandom_range(0, 99) < 2) rr_mode = ~rr_mode;
      applied_req  = req;
      applied_mode = rr_mode;
      step();
      check("rnd.onehot_a", 32'($onehot0(gnt_a)), 32'd1);
      check("rnd.id_a",     32'(gnt_id_a),        32'(enc(gnt_a)));
      check("rnd.vld_a",    32'(gnt_valid_a),     32'(|gnt_a));
      check("rnd.onehot_b", 32'($onehot0(gnt_b)), 32'd1);
      check("rnd.id_b",     32'(gnt_id_b),        32'(enc(gnt_b)));
      for (int k = 0; k < 4; k++) begin
        if (prev_gnt[k] && !applied_req[k]) begin
          check($sformatf("rnd.drop%0d", k), 32'(gnt_a[k]), 32'd0);
        end
        if (!applied_req[k] || applied_mode == 1'b0) begin
          wait_cnt[k] = 0;
        end else if (gnt_a != 4'b0000 && gnt_a != prev_gnt) begin
          if (gnt_a[k]) begin
            wait_cnt[k] = 0;
          end else begin
            wait_cnt[k]++;
            check($sformatf("rnd.starve%0d", k), 32'(wait_cnt[k] <= 4), 32'd1);
          end
        end
      end
      prev_gnt = gnt_a;
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
